pico_cpu_pipe: RTL and testbench

Parametrised next-generation picoMIPS core. Two stages: a registered fetch stage (PC → program ROM → instruction register) and an execute stage (decode, register read, ALU/multiplier, write-back). It adds width/depth/register-count parameters, an iterative multiplier with pipeline stall, a switch handshake instruction (WAIT), a dedicated OUT port and HALT. It is the top level of the processor, driven directly by board switches.

---
 rtl/picomips_pkg.sv | 33 +++
 rtl/mul_seq.sv | 56 +++++
 rtl/prog.sv | 67 ++++++
 rtl/pico_cpu_pipe.sv | 149 ++++++++++++++
 tb/tb_pico_cpu_pipe.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/picomips_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | picomips_pkg: opcodes, execute FSM states, instruction encoding   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package picomips_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,  OP_ADD  = 4'd1,  OP_ADDI = 4'd2,  OP_SUB  = 4'd3,
    OP_SUBI = 4'd4,  OP_MUL  = 4'd5,  OP_MULI = 4'd6,  OP_MOV  = 4'd7,
    OP_LDI  = 4'd8,  OP_IN   = 4'd9,  OP_OUT  = 4'd10, OP_BEQ  = 4'd11,
    OP_BNE  = 4'd12, OP_J    = 4'd13, OP_WAIT = 4'd14, OP_HALT = 4'd15
  } op_t;

  typedef enum logic [1:0] {
    ST_EXEC    = 2'd0,
    ST_MULT    = 2'd1,
    ST_WAITING = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  // NOP is the all-zero word at any instruction width.
  localparam int unsigned NOP_INSTR = 0;

  function automatic logic [31:0] enc_instr(input op_t op, input int unsigned rd,
                                            input int unsigned rs, input int unsigned imm,
                                            input int rbits, input int nn);
    return (32'(op) << (2*rbits + nn)) | (32'(rd) << (rbits + nn)) |
           (32'(rs) << nn) | 32'(imm);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mul_seq: unsigned right-shift add-and-shift multiplier, n steps   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module mul_seq #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] product_hi
);
  localparam int CW = $clog2(n + 1);
  localparam logic [CW-1:0] c_last = CW'(n - 1);

  logic [2*n-1:0] r_acc;
  logic [n-1:0]   r_mcand;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic [n:0]     w_sum;
  logic [2*n-1:0] w_next;

  assign w_sum  = {1'b0, r_acc[2*n-1:n]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
  assign w_next = {w_sum, r_acc[n-1:1]};

  // done and product_hi are valid together during the final step, so the
  // caller can write back on the same edge that completes the product.
  assign busy       = r_busy;
  assign done       = r_busy && (r_cnt == c_last);
  assign product_hi = w_next[2*n-1:n];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc   <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (start) begin
      r_acc   <= {{n{1'b0}}, b};
      r_mcand <= a;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_next;
      r_cnt <= r_cnt + CW'(1);
      if (done) r_busy <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog.sv
`default_nettype none
// +------------------------------------------------------------------+
// | prog: combinational program ROM                                   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module prog
  import picomips_pkg::*;
#(
  parameter int Psize = 6,
  parameter int Isize = 18,
  parameter int n     = 8
) (
  input  logic [Psize-1:0] address,
  output logic [Isize-1:0] I
);
  localparam int Rbits = (Isize - 4 - n) / 2;

  function automatic logic [Isize-1:0] w(input op_t op, input int unsigned rd,
                                         input int unsigned rs, input int unsigned imm);
    return Isize'(enc_instr(op, rd, rs, imm, Rbits, n));
  endfunction

  always_comb begin
    I = Isize'(NOP_INSTR);
    case (int'(address))
      0:  I = w(OP_LDI,  1, 0, 200);
      1:  I = w(OP_ADDI, 1, 0, 100);
      2:  I = w(OP_OUT,  0, 1, 0);
      3:  I = w(OP_LDI,  2, 0, 212);
      4:  I = w(OP_ADD,  1, 2, 0);
      5:  I = w(OP_OUT,  0, 1, 0);
      6:  I = w(OP_LDI,  1, 0, 128);
      7:  I = w(OP_LDI,  2, 0, 128);
      8:  I = w(OP_MUL,  1, 2, 0);
      9:  I = w(OP_OUT,  0, 1, 0);
      10: I = w(OP_LDI,  1, 0, 1);
      11: I = w(OP_SUBI, 1, 0, 1);
      12: I = w(OP_BEQ,  0, 0, 15);
      13: I = w(OP_LDI,  4, 0, 99);
      14: I = w(OP_OUT,  0, 4, 0);
      15: I = w(OP_OUT,  0, 4, 0);
      // Switch-driven loop: read a value, scale it, exit when it is zero.
      16: I = w(OP_WAIT, 0, 0, 1);
      17: I = w(OP_IN,   3, 0, 0);
      18: I = w(OP_WAIT, 0, 0, 0);
      19: I = w(OP_OUT,  0, 3, 0);
      20: I = w(OP_MOV,  5, 3, 0);
      21: I = w(OP_MULI, 5, 0, 200);
      22: I = w(OP_OUT,  0, 5, 0);
      23: I = w(OP_ADD,  5, 3, 0);
      24: I = w(OP_OUT,  0, 5, 0);
      25: I = w(OP_SUB,  5, 3, 0);
      26: I = w(OP_OUT,  0, 5, 0);
      27: I = w(OP_MOV,  0, 3, 0);
      28: I = w(OP_OUT,  0, 0, 0);
      29: I = w(OP_ADDI, 3, 0, 0);
      30: I = w(OP_BNE,  0, 0, 16);
      31: I = w(OP_J,    0, 0, 33);
      32: I = w(OP_LDI,  4, 0, 55);
      33: I = w(OP_OUT,  0, 4, 0);
      34: I = w(OP_HALT, 0, 0, 0);
      default: I = Isize'(NOP_INSTR);
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pico_cpu_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pico_cpu_pipe: two-stage parametrised picoMIPS core (top level)   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pico_cpu_pipe
  import picomips_pkg::*;
#(
  parameter int n     = 8,
  parameter int Psize = 6,
  parameter int NREG  = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n:0]   SW,
  output logic [n-1:0] outport,
  output logic         halted
);
  localparam int Rbits = $clog2(NREG);
  localparam int Isize = 4 + 2*Rbits + n;

  logic [Psize-1:0] r_pc;
  logic [Isize-1:0] r_ir, w_rom;
  state_t           r_state;
  logic             r_z;
  logic [n-1:0]     r_regs [NREG];

  op_t              w_op;
  logic [Rbits-1:0] w_rd, w_rs;
  logic [n-1:0]     w_imm, w_rd_val, w_rs_val, w_result, w_mul_b, w_mul_hi;
  logic             w_wr_en, w_z_en, w_out_en, w_taken, w_advance;
  logic             w_wait_ok, w_mul_start, w_mul_busy, w_mul_fin, w_mul_done;

  prog #(.Psize(Psize), .Isize(Isize), .n(n)) u_prog (
    .address(r_pc),
    .I      (w_rom)
  );

  assign w_op  = op_t'(r_ir[Isize-1 -: 4]);
  assign w_rd  = r_ir[Isize-5 -: Rbits];
  assign w_rs  = r_ir[Isize-5-Rbits -: Rbits];
  assign w_imm = r_ir[n-1:0];

  // R0 is never written, so it always reads as zero.
  assign w_rd_val  = r_regs[w_rd];
  assign w_rs_val  = r_regs[w_rs];
  assign w_wait_ok = (SW[n] == w_imm[0]);

  assign w_mul_start = (r_state == ST_EXEC) && ((w_op == OP_MUL) || (w_op == OP_MULI));
  assign w_mul_b     = (w_op == OP_MULI) ? w_imm : w_rs_val;
  assign w_mul_done  = w_mul_fin && w_mul_busy;

  mul_seq #(.n(n)) u_mul (
    .clk       (clk),
    .rst       (reset),
    .start     (w_mul_start),
    .a         (w_rd_val),
    .b         (w_mul_b),
    .busy      (w_mul_busy),
    .done      (w_mul_fin),
    .product_hi(w_mul_hi)
  );

  always_comb begin
    w_result  = '0;
    w_wr_en   = 1'b0;
    w_z_en    = 1'b0;
    w_out_en  = 1'b0;
    w_taken   = 1'b0;
    w_advance = 1'b0;
    case (r_state)
      ST_EXEC: begin
        w_advance = 1'b1;
        case (w_op)
          OP_ADD:  begin w_result = w_rd_val + w_rs_val; w_wr_en = 1'b1; w_z_en = 1'b1; end
          OP_ADDI: begin w_result = w_rd_val + w_imm;    w_wr_en = 1'b1; w_z_en = 1'b1; end
          OP_SUB:  begin w_result = w_rd_val - w_rs_val; w_wr_en = 1'b1; w_z_en = 1'b1; end
          OP_SUBI: begin w_result = w_rd_val - w_imm;    w_wr_en = 1'b1; w_z_en = 1'b1; end
          OP_MUL, OP_MULI: w_advance = 1'b0;
          OP_MOV:  begin w_result = w_rs_val;    w_wr_en = 1'b1; end
          OP_LDI:  begin w_result = w_imm;       w_wr_en = 1'b1; end
          OP_IN:   begin w_result = SW[n-1:0];   w_wr_en = 1'b1; end
          OP_OUT:  w_out_en = 1'b1;
          OP_BEQ:  w_taken = r_z;
          OP_BNE:  w_taken = !r_z;
          OP_J:    w_taken = 1'b1;
          OP_WAIT: w_advance = w_wait_ok;
          OP_HALT: w_advance = 1'b0;
          default: ;
        endcase
      end
      ST_MULT: begin
        if (w_mul_done) begin
          w_result  = w_mul_hi;
          w_wr_en   = 1'b1;
          w_z_en    = 1'b1;
          w_advance = 1'b1;
        end
      end
      ST_WAITING: w_advance = w_wait_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_wr_en && (w_rd != '0)) begin
      r_regs[w_rd] <= w_result;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EXEC;
      r_pc    <= '0;
      r_ir    <= Isize'(NOP_INSTR);
      r_z     <= 1'b0;
      outport <= '0;
      halted  <= 1'b0;
    end else begin
      case (r_state)
        ST_EXEC: begin
          if (w_mul_start)                      r_state <= ST_MULT;
          else if (w_op == OP_WAIT && !w_wait_ok) r_state <= ST_WAITING;
          else if (w_op == OP_HALT) begin
            r_state <= ST_HALTED;
            halted  <= 1'b1;
          end
        end
        ST_MULT:    if (w_mul_done) r_state <= ST_EXEC;
        ST_WAITING: if (w_wait_ok)  r_state <= ST_EXEC;
        default: ;
      endcase
      if (w_z_en)   r_z     <= (w_result == '0);
      if (w_out_en) outport <= w_rs_val;
      // A taken branch squashes the already-fetched fall-through instruction.
      if (w_taken) begin
        r_pc <= w_imm[Psize-1:0];
        r_ir <= Isize'(NOP_INSTR);
      end else if (w_advance) begin
        r_ir <= w_rom;
        r_pc <= r_pc + Psize'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pico_cpu_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pico_cpu_pipe: checks the core against an instruction-level    |
// | model of the program held in ROM. Rev 1.0                         |
// +------------------------------------------------------------------+
module tb_pico_cpu_pipe;
  import picomips_pkg::*;

  logic       clk, reset;
  logic [8:0] SW;
  logic [7:0] outport;
  logic       halted;
  int n_checks = 0;
  int n_pass   = 0;

  pico_cpu_pipe #(.n(8), .Psize(6), .NREG(8)) dut (
    .clk(clk), .reset(reset), .SW(SW), .outport(outport), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  op_t p_op [64];
  int  p_rd [64], p_rs [64], p_imm [64];
  int  m_pc, m_ir, m_mulcnt, m_in_count, m_out;
  int  m_regs [8];
  bit  m_z, m_halted;

  task automatic put(input int a, input op_t op, input int rd, input int rs, input int imm);
    p_op[a] = op; p_rd[a] = rd; p_rs[a] = rs; p_imm[a] = imm;
  endtask

  task automatic load_program();
    for (int i = 0; i < 64; i++) put(i, OP_NOP, 0, 0, 0);
    put(0, OP_LDI, 1, 0, 200);  put(1, OP_ADDI, 1, 0, 100); put(2, OP_OUT, 0, 1, 0);
    put(3, OP_LDI, 2, 0, 212);  put(4, OP_ADD, 1, 2, 0);    put(5, OP_OUT, 0, 1, 0);
    put(6, OP_LDI, 1, 0, 128);  put(7, OP_LDI, 2, 0, 128);  put(8, OP_MUL, 1, 2, 0);
    put(9, OP_OUT, 0, 1, 0);    put(10, OP_LDI, 1, 0, 1);   put(11, OP_SUBI, 1, 0, 1);
    put(12, OP_BEQ, 0, 0, 15);  put(13, OP_LDI, 4, 0, 99);  put(14, OP_OUT, 0, 4, 0);
    put(15, OP_OUT, 0, 4, 0);   put(16, OP_WAIT, 0, 0, 1);  put(17, OP_IN, 3, 0, 0);
    put(18, OP_WAIT, 0, 0, 0);  put(19, OP_OUT, 0, 3, 0);   put(20, OP_MOV, 5, 3, 0);
    put(21, OP_MULI, 5, 0, 200); put(22, OP_OUT, 0, 5, 0);  put(23, OP_ADD, 5, 3, 0);
    put(24, OP_OUT, 0, 5, 0);   put(25, OP_SUB, 5, 3, 0);   put(26, OP_OUT, 0, 5, 0);
    put(27, OP_MOV, 0, 3, 0);   put(28, OP_OUT, 0, 0, 0);   put(29, OP_ADDI, 3, 0, 0);
    put(30, OP_BNE, 0, 0, 16);  put(31, OP_J, 0, 0, 33);    put(32, OP_LDI, 4, 0, 55);
    put(33, OP_OUT, 0, 4, 0);   put(34, OP_HALT, 0, 0, 0);
  endtask

  task automatic model_reset();
    m_pc = 0; m_ir = -1; m_mulcnt = 0; m_in_count = 0; m_out = 0;
    m_z = 1'b0; m_halted = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 0;
  endtask

  task automatic set_reg(input int rd, input int v, input bit zf);
    if (rd != 0) m_regs[rd] = v;
    if (zf) m_z = (v == 0);
  endtask

  // One clock edge of the program: m_ir is the instruction in execute (-1 = NOP).
  task automatic model_edge(input logic [8:0] sw);
    op_t op;
    int rd, rs, imm, a, b;
    if (m_halted) return;
    if (m_ir < 0) begin m_ir = m_pc; m_pc = (m_pc + 1) % 64; return; end
    op = p_op[m_ir]; rd = p_rd[m_ir]; rs = p_rs[m_ir]; imm = p_imm[m_ir];
    a = m_regs[rd]; b = m_regs[rs];
    case (op)
      OP_ADD:  set_reg(rd, (a + b) % 256, 1'b1);
      OP_ADDI: set_reg(rd, (a + imm) % 256, 1'b1);
      OP_SUB:  set_reg(rd, (a - b + 256) % 256, 1'b1);
      OP_SUBI: set_reg(rd, (a - imm + 256) % 256, 1'b1);
      OP_MUL, OP_MULI: begin
        if (m_mulcnt < 8) begin m_mulcnt++; return; end
        m_mulcnt = 0;
        set_reg(rd, (a * ((op == OP_MUL) ? b : imm)) / 256, 1'b1);
      end
      OP_MOV:  set_reg(rd, b, 1'b0);
      OP_LDI:  set_reg(rd, imm, 1'b0);
      OP_IN:   begin set_reg(rd, int'(sw[7:0]), 1'b0); m_in_count++; end
      OP_OUT:  m_out = b;
      OP_BEQ, OP_BNE, OP_J: begin
        if (op == OP_J || (op == OP_BEQ && m_z) || (op == OP_BNE && !m_z)) begin
          m_pc = imm % 64; m_ir = -1; return;
        end
      end
      OP_WAIT: if (int'(sw[8]) != imm % 2) return;
      OP_HALT: begin m_halted = 1'b1; return; end
      default: ;
    endcase
    m_ir = m_pc; m_pc = (m_pc + 1) % 64;
  endtask

  task automatic tick(input logic [8:0] sw);
    SW = sw;
    @(posedge clk);
    model_edge(sw);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; SW = '0;
    #1;
    n_checks++; if (dut.r_pc !== 6'd0) $display("FAIL reset_pc: got %0d want 0", dut.r_pc); else n_pass++;
    n_checks++; if (outport !== 8'd0) $display("FAIL reset_out: got %0d want 0", outport); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
    for (int i = 1; i < 8; i++) begin
      n_checks++;
      if (dut.r_regs[i] !== 8'd0) $display("FAIL reset_r%0d: got %0d want 0", i, dut.r_regs[i]); else n_pass++;
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_arith();
    repeat (4) tick(9'h000);
    n_checks++; if (outport !== 8'd44) $display("FAIL wrap_out: got %0d want 44", outport); else n_pass++;
    n_checks++; if (dut.r_z !== 1'b0) $display("FAIL wrap_z: got %b want 0", dut.r_z); else n_pass++;
    repeat (2) tick(9'h000);
    n_checks++; if (dut.r_z !== 1'b1) $display("FAIL zero_z: got %b want 1", dut.r_z); else n_pass++;
    tick(9'h000);
    n_checks++; if (outport !== 8'd0) $display("FAIL zero_out: got %0d want 0", outport); else n_pass++;
  endtask

  task automatic test_mul();
    repeat (2) tick(9'h000);
    for (int i = 0; i < 8; i++) begin
      tick(9'h000);
      n_checks++; if (dut.r_pc !== 6'd9) $display("FAIL mul_hold%0d: pc %0d want 9", i, dut.r_pc); else n_pass++;
    end
    tick(9'h000);
    n_checks++; if (dut.r_pc !== 6'd10) $display("FAIL mul_release: pc %0d want 10", dut.r_pc); else n_pass++;
    n_checks++; if (dut.r_regs[1] !== 8'd64) $display("FAIL mul_r1: got %0d want 64", dut.r_regs[1]); else n_pass++;
    tick(9'h000);
    n_checks++; if (outport !== 8'd64) $display("FAIL mul_out: got %0d want 64", outport); else n_pass++;
  endtask

  task automatic test_branch();
    repeat (3) tick(9'h000);
    n_checks++; if (dut.r_pc !== 6'd15) $display("FAIL beq_target: pc %0d want 15", dut.r_pc); else n_pass++;
    tick(9'h000);
    n_checks++; if (dut.r_pc !== 6'd16) $display("FAIL beq_bubble: pc %0d want 16", dut.r_pc); else n_pass++;
    n_checks++; if (dut.r_regs[4] !== 8'd0) $display("FAIL beq_squash: r4 %0d want 0", dut.r_regs[4]); else n_pass++;
    tick(9'h000);
    n_checks++; if (outport !== 8'd0) $display("FAIL beq_out: got %0d want 0", outport); else n_pass++;
  endtask

  task automatic test_wait();
    for (int i = 0; i < 5; i++) begin
      tick(9'h000);
      n_checks++; if (dut.r_pc !== 6'd17) $display("FAIL wait_stall%0d: pc %0d want 17", i, dut.r_pc); else n_pass++;
    end
    tick(9'h1A5);
    n_checks++; if (dut.r_pc !== 6'd18) $display("FAIL wait_retire: pc %0d want 18", dut.r_pc); else n_pass++;
    tick(9'h1A5);
    tick(9'h0A5);
    tick(9'h0A5);
    n_checks++; if (outport !== 8'hA5) $display("FAIL wait_in_out: got %0h want a5", outport); else n_pass++;
  endtask

  task automatic test_random_loop();
    logic [8:0] sw;
    int cyc = 0;
    while (!m_halted && cyc < 4000) begin
      sw[8]   = 1'($urandom_range(0, 1));
      sw[7:0] = (m_in_count >= 6) ? 8'd0 : 8'($urandom_range(0, 255));
      tick(sw);
      cyc++;
      n_checks++; if (outport !== 8'(m_out)) $display("FAIL loop_out@%0d: got %0d want %0d", cyc, outport, m_out); else n_pass++;
      n_checks++; if (dut.r_pc !== 6'(m_pc)) $display("FAIL loop_pc@%0d: got %0d want %0d", cyc, dut.r_pc, m_pc); else n_pass++;
      n_checks++; if (halted !== m_halted) $display("FAIL loop_halted@%0d: got %b want %b", cyc, halted, m_halted); else n_pass++;
    end
    n_checks++; if (halted !== 1'b1) $display("FAIL loop_end: halted %b want 1 after %0d cycles", halted, cyc); else n_pass++;
  endtask

  task automatic test_halt();
    n_checks++; if (dut.r_pc !== 6'd35) $display("FAIL halt_pc: got %0d want 35", dut.r_pc); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      tick(9'($urandom_range(0, 511)));
      n_checks++; if (dut.r_pc !== 6'd35) $display("FAIL halt_frozen_pc%0d: got %0d want 35", i, dut.r_pc); else n_pass++;
      n_checks++; if (outport !== 8'd0) $display("FAIL halt_frozen_out%0d: got %0d want 0", i, outport); else n_pass++;
      n_checks++; if (halted !== 1'b1) $display("FAIL halt_sticky%0d: got %b want 1", i, halted); else n_pass++;
    end
  endtask

  task automatic test_reset_mid_mul();
    #2 reset = 1'b1;
    #1;
    n_checks++; if (halted !== 1'b0) $display("FAIL halt_reset: halted %b want 0", halted); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (12) tick(9'h000);
    n_checks++; if (dut.r_regs[1] !== 8'd128) $display("FAIL midmul_pre_r1: got %0d want 128", dut.r_regs[1]); else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (dut.r_regs[1] !== 8'd0) $display("FAIL midmul_r1: got %0d want 0", dut.r_regs[1]); else n_pass++;
    n_checks++; if (dut.r_pc !== 6'd0) $display("FAIL midmul_pc: got %0d want 0", dut.r_pc); else n_pass++;
    n_checks++; if (dut.r_z !== 1'b0) $display("FAIL midmul_z: got %b want 0", dut.r_z); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 24; i++) begin
      tick(9'h000);
      n_checks++; if (outport !== 8'(m_out)) $display("FAIL restart_out%0d: got %0d want %0d", i, outport, m_out); else n_pass++;
      n_checks++; if (dut.r_pc !== 6'(m_pc)) $display("FAIL restart_pc%0d: got %0d want %0d", i, dut.r_pc, m_pc); else n_pass++;
    end
  endtask

  initial begin
    load_program();
    model_reset();
    test_reset();
    test_arith();
    test_mul();
    test_branch();
    test_wait();
    test_random_loop();
    test_halt();
    test_reset_mid_mul();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
